waveform_ram_scheduler: RTL and testbench
=========================================

// Module: waveform_ram_scheduler
// PURPOSE
//  Single-port arbiter/scheduler for the shared 4K x 32 waveform sample RAM.
//  - Shares the RAM between the VGA display read path and two sample writers (ECG, EMG).
//  - Manages each channel's circular write region and publishes per-frame head pointers,
//    so the display scrolls without tearing.
//  - Sits between the ADC sample front-ends and the RAM; the VGA controller reads through it.
// PARAMETERS
//  ECG_BASE  12'h801  first RAM word of the ECG region
//  EMG_BASE  12'hC7F  first RAM word of the EMG region
//  DEPTH     640      words per region (one per screen column)
//  MAX_WAIT  7        cycles a pending writer may be starved before it pre-empts VGA
//  DECIM     4        decimation factor, used only when WFS_DECIM_EN is defined
// PORTS
//  clock         in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  ecg_valid     in   1   ECG sample offered
//  ecg_sample    in   12  ECG sample value
//  ecg_ready     out  1   ECG sample accepted this cycle (valid & ready)
//  emg_valid     in   1   EMG sample offered
//  emg_sample    in   12  EMG sample value
//  emg_ready     out  1   EMG sample accepted this cycle
//  vga_rd_req    in   1   display read request
//  vga_rd_addr   in   12  absolute RAM address to read
//  vga_rd_gnt    out  1   read issued to RAM this cycle
//  vga_rd_valid  out  1   vga_rd_data valid (one cycle after gnt)
//  vga_rd_data   out  32  read data
//  screen_end    in   1   one-cycle pulse at end of frame
//  ecg_head      out  10  ECG write pointer latched at last screen_end (oldest column)
//  emg_head      out  10  EMG write pointer latched at last screen_end
//  ram_addr      out  12  RAM address
//  ram_we        out  1   RAM write enable
//  ram_wdata     out  32  RAM write data = {20'd0, sample}
//  ram_rdata     in   32  RAM read data, 1-cycle latency
// BEHAVIOUR
//  - Reset: every output 0; wr_ptr_ecg/emg = 0; round-robin pointer = ECG; wait counters = 0.
//  - One RAM access per cycle. Priority, decided combinationally each cycle:
//      1. Starved writer: its wait count == MAX_WAIT; both starved -> RR pointer decides.
//      2. vga_rd_req.
//      3. Pending writers, round-robin.
//  - Grant signals:
//      - Write grant: ram_we=1, ram_addr = BASE + wr_ptr, x_ready=1 in the same cycle;
//        wr_ptr += 1, wrapping DEPTH-1 -> 0; RR pointer moves to the other channel.
//      - Read grant: vga_rd_gnt=1, ram_addr = vga_rd_addr;
//        next cycle vga_rd_valid=1, vga_rd_data = ram_rdata.
//      - Pre-empted read: gnt=0, no valid. The requester holds req/addr and retries.
//  - Wait counter: +1 each cycle valid is high and not granted, saturating at MAX_WAIT;
//    cleared on grant or when valid drops.
//  - Handshake: a writer holds valid/sample stable until ready; ready is never high without valid.
//  - Address bounds: addresses outside the written regions are unchecked on reads.
//    Writes never leave [BASE, BASE+DEPTH-1].
//  - screen_end:
//      - Copies wr_ptr_* into *_head; heads are stable for the whole frame.
//      - If screen_end coincides with a write grant, the head takes the pre-increment pointer.
//  - Reset mid-operation: in-flight read is discarded (vga_rd_valid=0 next cycle);
//    no write is issued in the reset cycle.
//  - Idle cycle (no requests): ram_we=0, ram_addr holds its previous value.
// CONFIGURATION
//  WFS_DECIM_EN defined:
//    - Each channel keeps a modulo-DECIM counter (reset 0).
//    - Every offered sample is accepted (ready=1 immediately, no RAM access) except when the
//      counter == 0; that sample competes for a write grant as normal.
//    - The counter advances on each acceptance.
//  WFS_DECIM_EN undefined: every accepted sample is written; the DECIM parameter is ignored.
// TESTING
//  1. Reset, ecg_valid=1 with sample 12'hABC, no VGA traffic
//     -> cycle 0: ram_we=1, ram_addr=12'h801, ram_wdata=32'h00000ABC, ecg_ready=1.
//  2. ECG and EMG valid together for 4 cycles
//     -> writes alternate ECG@801, EMG@C7F, ECG@802, EMG@C80.
//  3. Write 640 ECG samples, then one more
//     -> 641st goes to 12'h801 (wrap); screen_end right after -> ecg_head=1.
//  4. vga_rd_req held high, emg_valid held high
//     -> EMG starved 7 cycles, written on the 8th with vga_rd_gnt=0 that cycle;
//        read grants resume next cycle, vga_rd_valid trails each gnt by 1.
//  5. Read grant, then reset asserted the next cycle
//     -> vga_rd_valid=0, heads/pointers=0, ram_we=0.
//  6. WFS_DECIM_EN, DECIM=4, 8 consecutive ECG samples
//     -> 8 ready pulses, exactly 2 RAM writes (samples 0 and 4) at 801, 802.

Source files
------------

// File: rtl/waveform_ram_scheduler_if.sv
// ---------------------------------------------------------------------------
// waveform_ram_scheduler_if
//
// Bundles every non-clock signal of the waveform RAM scheduler: the two ADC
// sample writers (ECG, EMG), the VGA read port, the frame marker with the
// published head pointers, and the single-port RAM bus.
//
// Modports
//   slave  : the scheduler itself (waveform_ram_scheduler).
//   master : the surrounding system (ADC front-ends, VGA controller, RAM).
//
// Handshake rule for the writer channels (x = ecg / emg):
//   x_valid high offers x_sample. The sample is taken in the cycle where
//   x_valid && x_ready. Until then the writer holds x_valid and x_sample
//   stable. x_ready is never high while x_valid is low.
// VGA reads: vga_rd_gnt high means the read was issued to the RAM this cycle;
// vga_rd_valid/vga_rd_data follow one cycle later. Without a grant the
// requester keeps vga_rd_req and vga_rd_addr unchanged and retries.
// ---------------------------------------------------------------------------
interface waveform_ram_scheduler_if;
  // ECG writer
  logic        ecg_valid;
  logic [11:0] ecg_sample;
  logic        ecg_ready;
  // EMG writer
  logic        emg_valid;
  logic [11:0] emg_sample;
  logic        emg_ready;
  // VGA read port
  logic        vga_rd_req;
  logic [11:0] vga_rd_addr;
  logic        vga_rd_gnt;
  logic        vga_rd_valid;
  logic [31:0] vga_rd_data;
  // Frame marker and published heads
  logic        screen_end;
  logic [9:0]  ecg_head;
  logic [9:0]  emg_head;
  // RAM bus
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  ecg_valid, ecg_sample, emg_valid, emg_sample,
           vga_rd_req, vga_rd_addr, screen_end, ram_rdata,
    output ecg_ready, emg_ready, vga_rd_gnt, vga_rd_valid, vga_rd_data,
           ecg_head, emg_head, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output ecg_valid, ecg_sample, emg_valid, emg_sample,
           vga_rd_req, vga_rd_addr, screen_end, ram_rdata,
    input  ecg_ready, emg_ready, vga_rd_gnt, vga_rd_valid, vga_rd_data,
           ecg_head, emg_head, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/waveform_ram_scheduler.sv
// ---------------------------------------------------------------------------
// waveform_ram_scheduler
//
// Single-port arbiter for the shared 4K x 32 waveform sample RAM. One RAM
// access is issued per cycle, chosen between the VGA display read path and
// two sample writers (ECG, EMG). Each writer owns a circular region of DEPTH
// words starting at its BASE; the write pointers are copied into the
// published head pointers at every screen_end so the display can scroll
// from a frame-stable origin without tearing.
//
// Ports
//   clock  : system clock
//   reset  : synchronous, active-high reset
//   bus    : waveform_ram_scheduler_if.slave
//            ecg_* / emg_*   : valid/ready sample writers (12-bit samples)
//            vga_rd_*        : read request, grant, 1-cycle-later data
//            screen_end      : end-of-frame pulse
//            ecg/emg_head    : write pointer captured at last screen_end
//            ram_*           : RAM address / write enable / data, rdata has
//                              one cycle of latency
//
// Arbitration (evaluated combinationally each cycle)
//   1. A writer whose wait count reached MAX_WAIT (both: round-robin picks)
//   2. VGA read request
//   3. Pending writers, round-robin
//
// Optional feature: define WFS_DECIM_EN to enable per-channel decimation by
// DECIM. Only every DECIM-th accepted sample reaches the RAM; the others are
// acknowledged immediately without a RAM access. Without the macro every
// accepted sample is written and DECIM has no effect.
// ---------------------------------------------------------------------------
module waveform_ram_scheduler #(
  parameter logic [11:0] ECG_BASE = 12'h801,
  parameter logic [11:0] EMG_BASE = 12'hC7F,
  parameter int unsigned DEPTH    = 640,
  parameter int unsigned MAX_WAIT = 7,
  parameter int unsigned DECIM    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  waveform_ram_scheduler_if.slave  bus
);

  localparam int unsigned WW       = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [9:0]  PTR_LAST = 10'(DEPTH - 1);

  // Reject configurations the counters cannot represent.
  if (MAX_WAIT < 1 || DECIM < 1 || DEPTH < 1 || DEPTH > 1024) begin : g_param_check
    $error("waveform_ram_scheduler: illegal parameter value");
  end

  // Which requester owns the RAM this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ECG  = 2'd1,
    GNT_EMG  = 2'd2,
    GNT_VGA  = 2'd3
  } gnt_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  // rr_q: 0 = ECG preferred next, 1 = EMG preferred next
  logic          rr_q,          rr_d;
  logic [9:0]    wr_ptr_ecg_q,  wr_ptr_ecg_d;
  logic [9:0]    wr_ptr_emg_q,  wr_ptr_emg_d;
  logic [WW-1:0] wait_ecg_q,    wait_ecg_d;
  logic [WW-1:0] wait_emg_q,    wait_emg_d;
  logic [9:0]    ecg_head_q,    ecg_head_d;
  logic [9:0]    emg_head_q,    emg_head_d;
  logic          rd_valid_q,    rd_valid_d;
  // Last address driven; the RAM address bus holds it on idle cycles.
  logic [11:0]   ram_addr_q,    ram_addr_d;

  // -------------------------------------------------------------------------
  // Per-channel write requests and decimation
  // -------------------------------------------------------------------------
  logic ecg_req, emg_req;       // sample needs a RAM write slot
  logic ecg_accept, emg_accept; // sample taken this cycle (drives ready)
  gnt_e gnt;

`ifdef WFS_DECIM_EN
  localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DW-1:0] DEC_LAST = DW'(DECIM - 1);

  logic [DW-1:0] dec_ecg_q, dec_ecg_d;
  logic [DW-1:0] dec_emg_q, dec_emg_d;
  logic          ecg_skip,  emg_skip;

  // Samples at a non-zero phase are dropped on the floor: acknowledged at
  // once, no RAM slot used. Phase-zero samples compete for a write.
  always_comb begin
    ecg_req    = bus.ecg_valid && (dec_ecg_q == '0);
    emg_req    = bus.emg_valid && (dec_emg_q == '0);
    ecg_skip   = !reset && bus.ecg_valid && (dec_ecg_q != '0);
    emg_skip   = !reset && bus.emg_valid && (dec_emg_q != '0);
    ecg_accept = ecg_skip || (gnt == GNT_ECG);
    emg_accept = emg_skip || (gnt == GNT_EMG);

    dec_ecg_d = dec_ecg_q;
    if (ecg_accept) begin
      dec_ecg_d = (dec_ecg_q == DEC_LAST) ? '0 : dec_ecg_q + 1'b1;
    end
    dec_emg_d = dec_emg_q;
    if (emg_accept) begin
      dec_emg_d = (dec_emg_q == DEC_LAST) ? '0 : dec_emg_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dec_ecg_q <= '0;
      dec_emg_q <= '0;
    end else begin
      dec_ecg_q <= dec_ecg_d;
      dec_emg_q <= dec_emg_d;
    end
  end
`else
  always_comb begin
    ecg_req    = bus.ecg_valid;
    emg_req    = bus.emg_valid;
    ecg_accept = (gnt == GNT_ECG);
    emg_accept = (gnt == GNT_EMG);
  end
`endif

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  logic starved_ecg, starved_emg;

  always_comb begin
    starved_ecg = ecg_req && (wait_ecg_q == WAIT_MAX);
    starved_emg = emg_req && (wait_emg_q == WAIT_MAX);
    gnt = GNT_NONE;
    if (reset) begin
      // Nothing reaches the RAM in the reset cycle.
      gnt = GNT_NONE;
    end else if (starved_ecg && starved_emg) begin
      gnt = rr_q ? GNT_EMG : GNT_ECG;
    end else if (starved_ecg) begin
      gnt = GNT_ECG;
    end else if (starved_emg) begin
      gnt = GNT_EMG;
    end else if (bus.vga_rd_req) begin
      gnt = GNT_VGA;
    end else if (ecg_req && emg_req) begin
      gnt = rr_q ? GNT_EMG : GNT_ECG;
    end else if (ecg_req) begin
      gnt = GNT_ECG;
    end else if (emg_req) begin
      gnt = GNT_EMG;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    rr_d         = rr_q;
    wr_ptr_ecg_d = wr_ptr_ecg_q;
    wr_ptr_emg_d = wr_ptr_emg_q;
    wait_ecg_d   = wait_ecg_q;
    wait_emg_d   = wait_emg_q;
    ecg_head_d   = ecg_head_q;
    emg_head_d   = emg_head_q;
    rd_valid_d   = (gnt == GNT_VGA);
    ram_addr_d   = ram_addr_q;

    case (gnt)
      GNT_ECG: begin
        ram_addr_d   = ECG_BASE + {2'b00, wr_ptr_ecg_q};
        wr_ptr_ecg_d = (wr_ptr_ecg_q == PTR_LAST) ? '0 : wr_ptr_ecg_q + 10'd1;
        rr_d         = 1'b1;
      end
      GNT_EMG: begin
        ram_addr_d   = EMG_BASE + {2'b00, wr_ptr_emg_q};
        wr_ptr_emg_d = (wr_ptr_emg_q == PTR_LAST) ? '0 : wr_ptr_emg_q + 10'd1;
        rr_d         = 1'b0;
      end
      GNT_VGA: begin
        ram_addr_d = bus.vga_rd_addr;
      end
      default: begin
        ram_addr_d = ram_addr_q;
      end
    endcase

    // Starvation counters: count cycles a write request is left waiting,
    // saturating so the pre-emption condition stays asserted.
    if (!ecg_req || gnt == GNT_ECG) begin
      wait_ecg_d = '0;
    end else if (wait_ecg_q != WAIT_MAX) begin
      wait_ecg_d = wait_ecg_q + 1'b1;
    end
    if (!emg_req || gnt == GNT_EMG) begin
      wait_emg_d = '0;
    end else if (wait_emg_q != WAIT_MAX) begin
      wait_emg_d = wait_emg_q + 1'b1;
    end

    // Heads capture the registered pointers, so a write granted in the same
    // cycle as screen_end is not yet included (pre-increment value).
    if (bus.screen_end) begin
      ecg_head_d = wr_ptr_ecg_q;
      emg_head_d = wr_ptr_emg_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q         <= 1'b0;
      wr_ptr_ecg_q <= '0;
      wr_ptr_emg_q <= '0;
      wait_ecg_q   <= '0;
      wait_emg_q   <= '0;
      ecg_head_q   <= '0;
      emg_head_q   <= '0;
      rd_valid_q   <= 1'b0;
      ram_addr_q   <= '0;
    end else begin
      rr_q         <= rr_d;
      wr_ptr_ecg_q <= wr_ptr_ecg_d;
      wr_ptr_emg_q <= wr_ptr_emg_d;
      wait_ecg_q   <= wait_ecg_d;
      wait_emg_q   <= wait_emg_d;
      ecg_head_q   <= ecg_head_d;
      emg_head_q   <= emg_head_d;
      rd_valid_q   <= rd_valid_d;
      ram_addr_q   <= ram_addr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Everything is forced low while reset is high, which also drops
  // a read that was granted in the cycle before reset.
  // -------------------------------------------------------------------------
  logic [31:0] wdata;

  always_comb begin
    wdata = '0;
    case (gnt)
      GNT_ECG: wdata = {20'd0, bus.ecg_sample};
      GNT_EMG: wdata = {20'd0, bus.emg_sample};
      default: wdata = '0;
    endcase
  end

  assign bus.ecg_ready    = ecg_accept;
  assign bus.emg_ready    = emg_accept;
  assign bus.vga_rd_gnt   = (gnt == GNT_VGA);
  assign bus.vga_rd_valid = rd_valid_q && !reset;
  assign bus.vga_rd_data  = (rd_valid_q && !reset) ? bus.ram_rdata : 32'd0;
  assign bus.ecg_head     = reset ? 10'd0 : ecg_head_q;
  assign bus.emg_head     = reset ? 10'd0 : emg_head_q;
  assign bus.ram_addr     = reset ? 12'd0 : ram_addr_d;
  assign bus.ram_we       = (gnt == GNT_ECG) || (gnt == GNT_EMG);
  assign bus.ram_wdata    = wdata;

endmodule

// File: tb/tb_waveform_ram_scheduler.sv
// ---------------------------------------------------------------------------
// tb_waveform_ram_scheduler
//
// Directed bench for waveform_ram_scheduler. Inputs are driven 1 time unit
// after the rising edge, outputs are sampled on the falling edge of the same
// cycle. The RAM stand-in returns a recognisable word per address
// (32'hDEAD0000 | addr) one cycle after the address is presented.
// Build with +define+WFS_DECIM_EN to exercise the decimation variant.
// ---------------------------------------------------------------------------
module tb_waveform_ram_scheduler;

  // Clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  waveform_ram_scheduler_if bus ();

  waveform_ram_scheduler dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // RAM stand-in with one cycle of read latency.
  always @(posedge clock) begin
    bus.ram_rdata <= 32'hDEAD0000 | {20'd0, bus.ram_addr};
  end

  // Scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [11:0] a);
    return 32'hDEAD0000 | {20'd0, a};
  endfunction

  // Driver tasks
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ecg_valid   = 1'b0;
    bus.ecg_sample  = '0;
    bus.emg_valid   = 1'b0;
    bus.emg_sample  = '0;
    bus.vga_rd_req  = 1'b0;
    bus.vga_rd_addr = '0;
    bus.screen_end  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;

    // ---- Reset state, with an ECG sample already offered ----
    bus.ecg_valid  = 1'b1;
    bus.ecg_sample = 12'hABC;
    cyc();
    cyc();
    @(negedge clock);
    check("rst_we",    {31'd0, bus.ram_we},       32'd0);
    check("rst_ready", {31'd0, bus.ecg_ready},    32'd0);
    check("rst_addr",  {20'd0, bus.ram_addr},     32'd0);
    check("rst_valid", {31'd0, bus.vga_rd_valid}, 32'd0);
    check("rst_heads", {12'd0, bus.ecg_head, bus.emg_head}, 32'd0);
    cyc();
    reset = 1'b0;

    // ---- 1: first write after reset ----
    @(negedge clock);
    check("t1_we",    {31'd0, bus.ram_we},    32'd1);
    check("t1_addr",  {20'd0, bus.ram_addr},  32'h801);
    check("t1_wdata", bus.ram_wdata,          32'h00000ABC);
    check("t1_ready", {31'd0, bus.ecg_ready}, 32'd1);
    cyc();
    bus.ecg_valid = 1'b0;
    @(negedge clock);
    check("idle_we",   {31'd0, bus.ram_we},   32'd0);
    check("idle_addr", {20'd0, bus.ram_addr}, 32'h801);
    cyc();

    // ---- 2: ECG and EMG contend, round-robin alternation ----
    do_reset();
    exp_q.push_back(12'h801);
    exp_q.push_back(12'hC7F);
    exp_q.push_back(12'h802);
    exp_q.push_back(12'hC80);
    bus.ecg_valid = 1'b1;
    bus.emg_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ecg_sample = 12'h100 + 12'(i);
      bus.emg_sample = 12'h200 + 12'(i);
      @(negedge clock);
      check("t2_addr", {20'd0, bus.ram_addr}, {20'd0, exp_q.pop_front()});
      check("t2_we", {31'd0, bus.ram_we}, 32'd1);
      check("t2_rdy", {30'd0, bus.ecg_ready, bus.emg_ready},
            (i % 2 == 0) ? 32'b10 : 32'b01);
      check("t2_wdata", bus.ram_wdata,
            (i % 2 == 0) ? 32'h100 + 32'(i) : 32'h200 + 32'(i));
      cyc();
    end
    idle_inputs();

    // ---- 3: wrap after DEPTH writes, head capture ----
    do_reset();
    bus.ecg_valid = 1'b1;
    for (int i = 0; i < 641; i++) begin
      bus.ecg_sample = 12'(i);
      @(negedge clock);
      if (i == 639) check("t3_last", {20'd0, bus.ram_addr}, 32'hA80);
      if (i == 640) begin
        check("t3_wrap", {20'd0, bus.ram_addr}, 32'h801);
        check("t3_wrap_we", {31'd0, bus.ram_we}, 32'd1);
      end
      cyc();
    end
    bus.ecg_valid  = 1'b0;
    bus.screen_end = 1'b1;
    @(negedge clock);
    check("t3_head_old", {22'd0, bus.ecg_head}, 32'd0);
    cyc();
    bus.screen_end = 1'b0;
    @(negedge clock);
    check("t3_head", {22'd0, bus.ecg_head}, 32'd1);
    check("t3_emg_head", {22'd0, bus.emg_head}, 32'd0);
    cyc();
    // screen_end together with a write: head keeps the pre-increment pointer
    bus.ecg_valid  = 1'b1;
    bus.ecg_sample = 12'h3C3;
    bus.screen_end = 1'b1;
    @(negedge clock);
    check("t3_co_addr", {20'd0, bus.ram_addr}, 32'h802);
    cyc();
    bus.ecg_valid  = 1'b0;
    bus.screen_end = 1'b0;
    @(negedge clock);
    check("t3_co_head", {22'd0, bus.ecg_head}, 32'd1);
    cyc();
    bus.screen_end = 1'b1;
    cyc();
    bus.screen_end = 1'b0;
    @(negedge clock);
    check("t3_head2", {22'd0, bus.ecg_head}, 32'd2);
    cyc();

    // ---- 4: starved EMG pre-empts a continuous VGA read stream ----
    do_reset();
    bus.vga_rd_req = 1'b1;
    bus.emg_valid  = 1'b1;
    bus.emg_sample = 12'h055;
    for (int k = 0; k < 10; k++) begin
      if (k < 7)       bus.vga_rd_addr = 12'h010 + 12'(k);
      else if (k < 9)  bus.vga_rd_addr = 12'h017;
      else             bus.vga_rd_addr = 12'h018;
      if (k == 8) bus.emg_sample = 12'h056;
      @(negedge clock);
      if (k < 7) begin
        check("t4_gnt", {31'd0, bus.vga_rd_gnt}, 32'd1);
        check("t4_addr", {20'd0, bus.ram_addr}, 32'h010 + 32'(k));
        check("t4_nordy", {31'd0, bus.emg_ready}, 32'd0);
      end else if (k == 7) begin
        check("t4_pre_gnt", {31'd0, bus.vga_rd_gnt}, 32'd0);
        check("t4_pre_we", {31'd0, bus.ram_we}, 32'd1);
        check("t4_pre_addr", {20'd0, bus.ram_addr}, 32'hC7F);
        check("t4_pre_rdy", {31'd0, bus.emg_ready}, 32'd1);
        check("t4_pre_wd", bus.ram_wdata, 32'h055);
      end else begin
        check("t4_resume", {31'd0, bus.vga_rd_gnt}, 32'd1);
        check("t4_res_rdy", {31'd0, bus.emg_ready}, 32'd0);
      end
      if (k == 0 || k == 8) begin
        check("t4_novalid", {31'd0, bus.vga_rd_valid}, 32'd0);
        check("t4_nodata", bus.vga_rd_data, 32'd0);
      end else begin
        check("t4_valid", {31'd0, bus.vga_rd_valid}, 32'd1);
        check("t4_data", bus.vga_rd_data,
              (k == 9) ? pat(12'h017) : pat(12'h010 + 12'(k - 1)));
      end
      cyc();
    end

    // ---- 5: reset right after a read grant ----
    bus.emg_valid   = 1'b0;
    bus.vga_rd_addr = 12'h020;
    bus.screen_end  = 1'b1;
    @(negedge clock);
    check("t5_gnt", {31'd0, bus.vga_rd_gnt}, 32'd1);
    cyc();
    idle_inputs();
    reset          = 1'b1;
    bus.ecg_valid  = 1'b1;
    bus.ecg_sample = 12'h111;
    @(negedge clock);
    check("t5_valid", {31'd0, bus.vga_rd_valid}, 32'd0);
    check("t5_we", {31'd0, bus.ram_we}, 32'd0);
    check("t5_rdy", {31'd0, bus.ecg_ready}, 32'd0);
    check("t5_head", {22'd0, bus.emg_head}, 32'd0);
    cyc();
    reset          = 1'b0;
    bus.ecg_valid  = 1'b0;
    bus.emg_valid  = 1'b1;
    bus.emg_sample = 12'h077;
    @(negedge clock);
    check("t5_post_valid", {31'd0, bus.vga_rd_valid}, 32'd0);
    check("t5_post_head", {22'd0, bus.emg_head}, 32'd0);
    check("t5_post_addr", {20'd0, bus.ram_addr}, 32'hC7F);
    cyc();
    idle_inputs();

    // ---- 6: eight back-to-back ECG samples ----
    do_reset();
    bus.ecg_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.ecg_sample = 12'h500 + 12'(i);
      @(negedge clock);
      check("t6_rdy", {31'd0, bus.ecg_ready}, 32'd1);
`ifdef WFS_DECIM_EN
      check("t6_we", {31'd0, bus.ram_we}, (i % 4 == 0) ? 32'd1 : 32'd0);
      if (i == 0) check("t6_addr0", {20'd0, bus.ram_addr}, 32'h801);
      if (i == 4) check("t6_addr4", {20'd0, bus.ram_addr}, 32'h802);
`else
      check("t6_we", {31'd0, bus.ram_we}, 32'd1);
      check("t6_addr", {20'd0, bus.ram_addr}, 32'h801 + 32'(i));
`endif
      cyc();
    end
    idle_inputs();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
